actor_move_engine: RTL and testbench
====================================

// Module: actor_move_engine
// PURPOSE
//  Hardware successor to the CPU "CharLogic/TryMove/IsValid" routine: steps NUM_ACTORS grid actors
//  (pacman, ghosts) once per movement period. For each actor it tries the desired direction, then
//  falls back to the current one. Walls come from a shared map-query handshake (arbitrated to MapData).
//  Holds the per-actor x/y/dir that feed the sprite renderers; the CPU only writes desired dirs and inits.
// PARAMETERS
//  NUM_ACTORS  4   number of actors, indices 0..NUM_ACTORS-1 (0 = player)
//  COORD_W     5   coordinate width in tiles
//  MAP_MAX     28  valid coords are 1..MAP_MAX-1 on both axes
//  STEP_DIV    1   a step pass runs on every STEP_DIV-th frame_tick (>=1)
//  ID_W        2   actor index width, >= clog2(NUM_ACTORS)
// PORTS
//  clk          in   1                     clock
//  reset        in   1                     synchronous, active-low reset
//  frame_tick   in   1                     1-cycle pulse per video frame
//  enable       in   1                     0: triggers are counted but no pass starts
//  desired_dir  in   2*NUM_ACTORS          packed desired direction, actor i at [2i+1:2i]
//  init_we      in   1                     write init_x/y/dir into actor init_id
//  init_id      in   ID_W                  actor to initialise
//  init_x/init_y in  COORD_W each          initial position
//  init_dir     in   2                     initial direction
//  map_req      out  1                     map query request
//  map_x/map_y  out  COORD_W each          tile queried, stable while map_req=1
//  map_ack      in   1                     query complete; may assert in the same cycle as map_req
//  map_wall     in   1                     1 = wall; sampled only when map_req&map_ack
//  pos_x/pos_y  out  COORD_W*NUM_ACTORS    packed actor positions
//  dir          out  2*NUM_ACTORS          packed actor directions
//  moved        out  NUM_ACTORS            bit i = actor i changed position in the last pass
//  busy         out  1                     pass in progress (any state but IDLE)
//  done         out  1                     1-cycle pulse at end of pass
//  overrun      out  1                     sticky: a trigger arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (reset=0 at posedge): all pos/dir=0, moved=0, busy=0, done=0, map_req=0, overrun=0,
//   divider=0, state=IDLE. A reset mid-pass abandons the pass. A partially committed pass is not undone.
//  Direction vectors: 0=(0,-1) up, 1=(-1,0) left, 2=(0,+1) down, 3=(+1,0) right.
//   Arithmetic is modulo 2^COORD_W, so 0-1 wraps to all-ones and is caught by the bound check.
//  Divider: every frame_tick increments div (0..STEP_DIV-1, wraps). The tick with div==STEP_DIV-1
//   is the "trigger".
//   - Trigger in IDLE with enable=1: start a pass. With enable=0: no pass and no overrun.
//   - Trigger while busy: dropped, overrun<=1.
//  init_we: accepted only in IDLE and ignored while busy. If it coincides with a trigger, the write
//   lands that cycle and the pass uses the new values.
//  FSM: IDLE -> CALC -> QUERY -> COMMIT -> (CALC next actor | DONE) -> IDLE.
//   CALC (1 cycle): candidate = pos[i] + vec(try_dir). try_dir = desired on the first try and the
//    current dir on the fallback. If candidate x or y is 0 or >= MAP_MAX, it is invalid: skip QUERY,
//    go to COMMIT.
//   QUERY: map_req=1 with map_x/map_y = candidate, held until map_ack. wall = map_wall in the ack
//    cycle. map_req drops the next cycle.
//   COMMIT (1 cycle):
//    - Valid on the desired try: pos<=candidate, dir<=desired, moved[i]=1.
//    - Invalid on the desired try with desired!=dir[i]: back to CALC as fallback.
//    - Invalid on the desired try with desired==dir[i]: no second query; treated as a failed fallback.
//    - Valid on the fallback: pos<=candidate, dir unchanged, moved[i]=1.
//    - Invalid on the fallback: hold pos and dir, moved[i]=0.
//   DONE (1 cycle): done=1, busy=1. Next cycle IDLE with busy=0.
//  Actors are processed in index order 0..NUM_ACTORS-1. desired_dir is sampled in each actor's first
//   CALC. moved is cleared at pass start.
//  Latency with map_ack tied to map_req: 3 cycles per actor per try. done is high in cycle
//   3*NUM_ACTORS+1 after the trigger, with no fallbacks.
// TESTING
//  1. NUM_ACTORS=2, ack=req, wall=0. Init a0=(2,2,d3), a1=(27,27,d1), desired=(3,1), trigger ->
//     a0=(3,2), a1=(26,27), moved=2'b11, done in cycle 7.
//  2. a0=(2,2,d3), desired=0, wall=1 only at (2,1) -> fallback moves a0 to (3,2), dir stays 3,
//     exactly 2 map_req handshakes.
//  3. a0=(1,5,d1), desired=1 -> candidate x=0 is out of bounds. No map_req for a0; pos and dir held;
//     moved[0]=0.
//  4. Map ack delayed 5 cycles -> map_x/map_y stable throughout; a second trigger sent during the
//     stall sets overrun=1 and that pass is dropped.
//  5. STEP_DIV=3 -> passes start only on ticks 3, 6, 9; init_we while busy leaves state unchanged.
//  6. reset=0 asserted during QUERY -> next cycle all outputs at reset values; pass abandoned.

Source files
------------

// File: rtl/actor_move_engine_if.sv
// Map-query handshake between the actor move engine (master) and the shared map arbiter (slave).
// map_x/map_y are held stable by the master while map_req is high.
interface actor_move_engine_if #(
  parameter int COORD_W = 5
);
  logic               map_req;
  logic [COORD_W-1:0] map_x;
  logic [COORD_W-1:0] map_y;
  logic               map_ack;
  logic               map_wall;

  modport master (output map_req, map_x, map_y, input map_ack, map_wall);
  modport slave  (input map_req, map_x, map_y, output map_ack, map_wall);
endinterface

// File: rtl/actor_move_engine.sv
// Steps every grid actor once per movement period: try the desired direction, fall back to the
// current one, with walls looked up through the shared map-query handshake.
module actor_move_engine #(
  parameter int NUM_ACTORS = 4,
  parameter int COORD_W    = 5,
  parameter int MAP_MAX    = 28,
  parameter int STEP_DIV   = 1,
  parameter int ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          enable,
  input  logic [2*NUM_ACTORS-1:0]       desired_dir,
  input  logic                          init_we,
  input  logic [ID_W-1:0]               init_id,
  input  logic [COORD_W-1:0]            init_x,
  input  logic [COORD_W-1:0]            init_y,
  input  logic [1:0]                    init_dir,
  actor_move_engine_if.master           map,
  output logic [COORD_W*NUM_ACTORS-1:0] pos_x,
  output logic [COORD_W*NUM_ACTORS-1:0] pos_y,
  output logic [2*NUM_ACTORS-1:0]       dir,
  output logic [NUM_ACTORS-1:0]         moved,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int          DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [31:0] MAP_LIM  = 32'(MAP_MAX);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_ACTORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_QUERY, S_COMMIT, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [COORD_W-1:0] px_reg  [NUM_ACTORS];
  logic [COORD_W-1:0] py_reg  [NUM_ACTORS];
  logic [1:0]         dir_reg [NUM_ACTORS];
  logic [1:0]         desired_arr [NUM_ACTORS];
  logic [NUM_ACTORS-1:0] moved_reg;

  logic [ID_W-1:0]    idx_reg;
  logic               fallback_reg;
  logic [1:0]         want_reg;
  logic [COORD_W-1:0] cand_x_reg, cand_y_reg;
  logic               cand_ok_reg;
  logic               wall_reg;
  logic [DIV_W-1:0]   div_reg;
  logic               overrun_reg;

  logic               trigger, start;
  logic [COORD_W-1:0] cur_x, cur_y, calc_x, calc_y;
  logic [1:0]         try_dir;
  logic               calc_ok, commit_ok, retry, last_actor;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACTORS; gi++) begin : g_pack
      assign desired_arr[gi]                  = desired_dir[2*gi +: 2];
      assign pos_x[gi*COORD_W +: COORD_W]     = px_reg[gi];
      assign pos_y[gi*COORD_W +: COORD_W]     = py_reg[gi];
      assign dir[2*gi +: 2]                   = dir_reg[gi];
    end
  endgenerate

  assign moved   = moved_reg;
  assign overrun = overrun_reg;
  assign map.map_x = cand_x_reg;
  assign map.map_y = cand_y_reg;

  assign trigger    = frame_tick && (div_reg == DIV_W'(STEP_DIV - 1));
  assign start      = trigger && enable && (state_reg == S_IDLE);
  assign cur_x      = px_reg[idx_reg];
  assign cur_y      = py_reg[idx_reg];
  assign try_dir    = fallback_reg ? dir_reg[idx_reg] : desired_arr[idx_reg];
  assign last_actor = (idx_reg == LAST_ID);
  assign commit_ok  = cand_ok_reg && !wall_reg;
  // A failed desired try only earns a second attempt when the current direction differs.
  assign retry      = !fallback_reg && !commit_ok && (want_reg != dir_reg[idx_reg]);

  // Wrapping arithmetic: stepping off 0 yields all-ones, which the upper bound rejects.
  always_comb begin
    calc_x = cur_x;
    calc_y = cur_y;
    case (try_dir)
      2'd0: calc_y = cur_y - COORD_W'(1);
      2'd1: calc_x = cur_x - COORD_W'(1);
      2'd2: calc_y = cur_y + COORD_W'(1);
      default: calc_x = cur_x + COORD_W'(1);
    endcase
  end

  assign calc_ok = (calc_x != '0) && (calc_y != '0) &&
                   (32'(calc_x) < MAP_LIM) && (32'(calc_y) < MAP_LIM);

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    map.map_req = 1'b0;
    busy        = (state_reg != S_IDLE);
    done        = 1'b0;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_CALC;
      S_CALC:   state_next = calc_ok ? S_QUERY : S_COMMIT;
      S_QUERY: begin
        map.map_req = 1'b1;
        if (map.map_ack) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        if (retry)           state_next = S_CALC;
        else if (last_actor) state_next = S_DONE;
        else                 state_next = S_CALC;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ACTORS; i++) begin
        px_reg[i]  <= '0;
        py_reg[i]  <= '0;
        dir_reg[i] <= '0;
      end
      moved_reg    <= '0;
      idx_reg      <= '0;
      fallback_reg <= 1'b0;
      want_reg     <= '0;
      cand_x_reg   <= '0;
      cand_y_reg   <= '0;
      cand_ok_reg  <= 1'b0;
      wall_reg     <= 1'b0;
      div_reg      <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      if (frame_tick) div_reg <= trigger ? '0 : div_reg + DIV_W'(1);
      if (trigger && state_reg != S_IDLE) overrun_reg <= 1'b1;

      // The CPU may only rewrite actors between passes; a write alongside a start is seen by it.
      if (init_we && state_reg == S_IDLE) begin
        px_reg[init_id]  <= init_x;
        py_reg[init_id]  <= init_y;
        dir_reg[init_id] <= init_dir;
      end

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            moved_reg    <= '0;
            idx_reg      <= '0;
            fallback_reg <= 1'b0;
          end
        end
        S_CALC: begin
          if (!fallback_reg) want_reg <= desired_arr[idx_reg];
          cand_x_reg  <= calc_x;
          cand_y_reg  <= calc_y;
          cand_ok_reg <= calc_ok;
        end
        S_QUERY: begin
          if (map.map_ack) wall_reg <= map.map_wall;
        end
        S_COMMIT: begin
          if (commit_ok) begin
            px_reg[idx_reg]    <= cand_x_reg;
            py_reg[idx_reg]    <= cand_y_reg;
            moved_reg[idx_reg] <= 1'b1;
            if (!fallback_reg) dir_reg[idx_reg] <= want_reg;
          end
          if (retry) begin
            fallback_reg <= 1'b1;
          end else begin
            fallback_reg <= 1'b0;
            if (!last_actor) idx_reg <= idx_reg + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_actor_move_engine.sv
// Scoreboard bench for actor_move_engine: stimulus pushes expected pass results, a monitor pops
// and compares them whenever done pulses. Two actors, divide-by-3 movement period.
`timescale 1ns/1ps
module tb_actor_move_engine;
  localparam int N  = 2;
  localparam int CW = 5;
  localparam int SD = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic enable = 1'b0;
  logic [2*N-1:0] desired_dir = '0;
  logic init_we = 1'b0;
  logic [0:0] init_id = '0;
  logic [CW-1:0] init_x = '0;
  logic [CW-1:0] init_y = '0;
  logic [1:0] init_dir = '0;
  logic [CW*N-1:0] pos_x, pos_y;
  logic [2*N-1:0] dir;
  logic [N-1:0] moved;
  logic busy, done, overrun;

  actor_move_engine_if #(.COORD_W(CW)) bus ();

  actor_move_engine #(
    .NUM_ACTORS(N), .COORD_W(CW), .MAP_MAX(28), .STEP_DIV(SD), .ID_W(1)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .desired_dir(desired_dir), .init_we(init_we), .init_id(init_id),
    .init_x(init_x), .init_y(init_y), .init_dir(init_dir), .map(bus),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moved(moved),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Map responder: ack after ack_delay extra cycles of map_req, walls at up to two tiles.
  int ack_delay = 0;
  int stall_cnt = 0;
  logic wall_a_en = 1'b0, wall_b_en = 1'b0;
  logic [CW-1:0] wall_ax = '0, wall_ay = '0, wall_bx = '0, wall_by = '0;

  assign bus.map_ack  = bus.map_req && (stall_cnt > ack_delay);
  assign bus.map_wall = (wall_a_en && bus.map_x == wall_ax && bus.map_y == wall_ay) ||
                        (wall_b_en && bus.map_x == wall_bx && bus.map_y == wall_by);

  always @(posedge clk) begin
    #1;
    if (!bus.map_req) stall_cnt = 0;
    else              stall_cnt++;
  end

  typedef struct {
    logic [CW*N-1:0] px;
    logic [CW*N-1:0] py;
    logic [2*N-1:0]  d;
    logic [N-1:0]    mv;
    int              lat;
    int              hs;
    string           name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0, trig_cyc = 0, hs_cnt = 0, done_cnt = 0, req_len = 0;
  int div_model = 0;
  logic prev_req = 1'b0;
  logic [CW-1:0] lx = '0, ly = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.map_req === 1'b1) begin
      if (!prev_req) begin
        lx = bus.map_x;
        ly = bus.map_y;
        req_len = 0;
      end
      req_len++;
      if (bus.map_ack === 1'b1) begin
        hs_cnt++;
        if (req_len > 1) begin
          chk("map_x_stable", 32'(bus.map_x), 32'(lx));
          chk("map_y_stable", 32'(bus.map_y), 32'(ly));
        end
      end
    end
    prev_req = bus.map_req;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_pos_x"}, 32'(pos_x), 32'(e.px));
        chk({e.name, "_pos_y"}, 32'(pos_y), 32'(e.py));
        chk({e.name, "_dir"},   32'(dir),   32'(e.d));
        chk({e.name, "_moved"}, 32'(moved), 32'(e.mv));
        if (e.lat >= 0) chk({e.name, "_latency"}, 32'(cyc - trig_cyc), 32'(e.lat));
        if (e.hs >= 0)  chk({e.name, "_handshakes"}, 32'(hs_cnt), 32'(e.hs));
      end
    end
  end

  task automatic tick(input bit start_expected);
    @(negedge clk);
    frame_tick = 1'b1;
    if (div_model == SD - 1) begin
      div_model = 0;
      if (start_expected) begin
        trig_cyc = cyc;
        hs_cnt   = 0;
      end
    end else begin
      div_model++;
    end
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic trigger(input bit start_expected);
    bit fired;
    fired = 1'b0;
    while (!fired) begin
      fired = (div_model == SD - 1);
      tick(start_expected && fired);
    end
  endtask

  task automatic init_actor(input int id, input int x, input int y, input int d);
    @(negedge clk);
    init_we  = 1'b1;
    init_id  = 1'(id);
    init_x   = CW'(x);
    init_y   = CW'(y);
    init_dir = 2'(d);
    @(negedge clk);
    init_we  = 1'b0;
  endtask

  task automatic expect_pass(input string nm, input int x0, input int y0, input int d0,
                             input int x1, input int y1, input int d1,
                             input int mv, input int lat, input int hs);
    exp_t x;
    x.px   = {CW'(x1), CW'(y0 * 0 + x0)};
    x.py   = {CW'(y1), CW'(y0)};
    x.d    = {2'(d1), 2'(d0)};
    x.mv   = N'(mv);
    x.lat  = lat;
    x.hs   = hs;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int start_cnt;
    int n;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start_cnt) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", nm, budget);
    end
    @(negedge clk);
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (bus.map_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.map_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_req_timeout: got no map_req expected map_req", nm);
    end
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_pos_x"},   32'(pos_x), 32'd0);
    chk({nm, "_pos_y"},   32'(pos_y), 32'd0);
    chk({nm, "_dir"},     32'(dir), 32'd0);
    chk({nm, "_moved"},   32'(moved), 32'd0);
    chk({nm, "_busy"},    32'(busy), 32'd0);
    chk({nm, "_done"},    32'(done), 32'd0);
    chk({nm, "_map_req"}, 32'(bus.map_req), 32'd0);
    chk({nm, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;

    // Both actors step in their desired directions, no walls.
    init_actor(0, 2, 2, 3);
    init_actor(1, 27, 27, 1);
    desired_dir = {2'd1, 2'd3};
    expect_pass("t1", 3, 2, 3, 26, 27, 1, 2'b11, 7, 2);
    trigger(1'b1);
    wait_done("t1", 100);

    // Desired up hits a wall, fallback right succeeds; actor 1 is blocked by the left border.
    wall_a_en = 1'b1; wall_ax = 5'd2; wall_ay = 5'd1;
    init_actor(0, 2, 2, 3);
    init_actor(1, 1, 5, 1);
    desired_dir = {2'd1, 2'd0};
    expect_pass("t2", 3, 2, 3, 1, 5, 1, 2'b01, 9, 2);
    trigger(1'b1);
    wait_done("t2", 100);
    wall_a_en = 1'b0;

    // Left border on actor 0: no query, held in place.
    init_actor(0, 1, 5, 1);
    init_actor(1, 27, 27, 1);
    desired_dir = {2'd1, 2'd1};
    expect_pass("t3", 1, 5, 1, 26, 27, 1, 2'b10, 6, 1);
    trigger(1'b1);
    wait_done("t3", 100);

    // Bottom border (y would be MAP_MAX) on actor 0; actor 1 turns right.
    init_actor(0, 5, 27, 2);
    init_actor(1, 10, 10, 0);
    desired_dir = {2'd3, 2'd2};
    expect_pass("t3b", 5, 27, 2, 11, 10, 3, 2'b10, 6, 1);
    trigger(1'b1);
    wait_done("t3b", 100);

    // Desired and fallback both walled: actor 0 holds after two queries.
    wall_a_en = 1'b1; wall_ax = 5'd5; wall_ay = 5'd4;
    wall_b_en = 1'b1; wall_bx = 5'd6; wall_by = 5'd5;
    init_actor(0, 5, 5, 3);
    init_actor(1, 3, 3, 2);
    desired_dir = {2'd2, 2'd0};
    expect_pass("t3c", 5, 5, 3, 3, 4, 2, 2'b10, 10, 3);
    trigger(1'b1);
    wait_done("t3c", 100);
    wall_a_en = 1'b0;
    wall_b_en = 1'b0;

    // Disabled trigger: no pass, no overrun.
    enable = 1'b0;
    trigger(1'b0);
    chk("disabled_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("disabled_overrun", 32'(overrun), 32'd0);
    enable = 1'b1;

    // Slow map: a trigger during the stall is dropped and flags overrun.
    ack_delay = 12;
    init_actor(0, 10, 10, 0);
    init_actor(1, 20, 20, 3);
    desired_dir = {2'd3, 2'd0};
    expect_pass("t4", 10, 9, 0, 21, 20, 3, 2'b11, 31, 2);
    trigger(1'b1);
    wait_req("t4");
    trigger(1'b0);
    chk("t4_overrun", 32'(overrun), 32'd1);
    wait_done("t4", 100);
    repeat (40) @(negedge clk);
    chk("t4_idle_after", 32'(busy), 32'd0);

    // Reset in the middle of a query abandons the pass.
    trigger(1'b0);
    wait_req("t6");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("t6");
    reset     = 1'b1;
    ack_delay = 0;
    div_model = 0;
    repeat (40) @(negedge clk);
    chk("t6_idle_after", 32'(busy), 32'd0);

    // Divide-by-3: passes only on ticks 3, 6, 9; init_we during a pass is ignored.
    init_actor(0, 4, 4, 3);
    init_actor(1, 8, 8, 2);
    desired_dir = {2'd2, 2'd3};
    for (int k = 1; k <= 9; k++) begin
      if (k % 3 == 0)
        expect_pass($sformatf("t5_pass%0d", k / 3), 4 + k / 3, 4, 3, 8, 8 + k / 3, 2, 2'b11, 7, 2);
      tick(k % 3 == 0);
      chk($sformatf("t5_busy_tick%0d", k), 32'(busy), 32'(k % 3 == 0));
      if (k == 6) begin
        init_we  = 1'b1;
        init_id  = 1'b0;
        init_x   = 5'd20;
        init_y   = 5'd20;
        init_dir = 2'd0;
        @(negedge clk);
        init_we  = 1'b0;
      end
      repeat (12) @(negedge clk);
    end
    chk("t5_scoreboard_empty", 32'(sb.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
